// File: rtl/slow_clk_monitor.sv
// slow_clk_monitor
//   Receive side of the divided-clock path. The slow square wave is treated
//   as data: it is synchronized into the clk domain, its edges become
//   one-cycle strobes, every half-period is measured in clk cycles, and lock
//   and stuck status are reported.
//
// Optional feature: define SLOW_CLK_MONITOR_GLITCH_FILTER_EN to add the
//   FILT_CYCLES parameter. The synchronized level must then hold for
//   FILT_CYCLES consecutive cycles before it is accepted as an edge.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   slow_in      slow square wave, asynchronous to clk
//   rise_pulse   one-cycle strobe per accepted 0->1 transition
//   fall_pulse   one-cycle strobe per accepted 1->0 transition
//   half_period  last measured edge-to-edge interval (clk cycles)
//   half_valid   one-cycle strobe: half_period updated this cycle
//   locked       level: stable in-tolerance input
//   stuck        level: no edge for TIMEOUT cycles
module slow_clk_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned EXPECT_HALF = 250001,
  parameter int unsigned TOL         = 16,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned TIMEOUT     = 600000
`ifdef SLOW_CLK_MONITOR_GLITCH_FILTER_EN
  , parameter int unsigned FILT_CYCLES = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             half_valid,
  output logic             locked,
  output logic             stuck
);

  localparam logic [1:0] ST_UNLOCK  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [1:0] ST_STUCK   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO_M1  = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);
  // Lower bound clamps at zero rather than wrapping.
  localparam int unsigned LO_BOUND = (EXPECT_HALF > TOL) ? (EXPECT_HALF - TOL) : 0;
  localparam int unsigned HI_BOUND = EXPECT_HALF + TOL;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_last;
  logic                   hist_q;
  logic                   edge_det;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       meas;
  logic                   in_tol;
  logic                   timeout_hit;
  logic [1:0]             state_q, state_d;
  logic [3:0]             good_q, good_d;
  logic [3:0]             good_inc;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   hv_q, hv_d;
  logic [CNT_W-1:0]       hp_q, hp_d;

  // Synchronizer chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], slow_in};
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

`ifdef SLOW_CLK_MONITOR_GLITCH_FILTER_EN
  localparam int unsigned FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  logic [FW-1:0] filt_q, filt_d;

  // Counts consecutive cycles the synchronized level differs from the
  // accepted level; any return to the accepted level restarts the count.
  always_comb begin
    filt_d   = '0;
    edge_det = 1'b0;
    if (sync_last != hist_q) begin
      if (filt_q == FW'(FILT_CYCLES - 1)) edge_det = 1'b1;
      else                                filt_d   = filt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) filt_q <= '0;
    else     filt_q <= filt_d;
  end
`else
  assign edge_det = sync_last ^ hist_q;
`endif

  // History flop holds the accepted level
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           hist_q <= 1'b0;
    else if (edge_det) hist_q <= sync_last;
  end

  // Saturating increment doubles as the measurement M = cnt + 1
  assign meas        = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
  assign cnt_d       = edge_det ? '0 : meas;
  assign in_tol      = (32'(meas) >= LO_BOUND) && (32'(meas) <= HI_BOUND);
  assign timeout_hit = !edge_det && (cnt_q == TMO_M1);
  assign good_inc    = good_q + 4'd1;

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    hv_d    = 1'b0;
    hp_d    = hp_q;
    rise_d  = edge_det & sync_last;
    fall_d  = edge_det & ~sync_last;
    if (edge_det) begin
      // Edges in UNLOCK/STUCK are reference edges and carry no measurement
      if ((state_q == ST_ACQUIRE) || (state_q == ST_LOCKED)) begin
        hv_d = 1'b1;
        hp_d = meas;
      end
      case (state_q)
        ST_ACQUIRE: begin
          if (in_tol) begin
            good_d = good_inc;
            if (good_inc >= LOCK_N) state_d = ST_LOCKED;
          end else begin
            good_d = '0;
          end
        end
        ST_LOCKED: begin
          if (!in_tol) begin
            state_d = ST_ACQUIRE;
            good_d  = '0;
          end
        end
        default: begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
      endcase
    end else if (timeout_hit) begin
      state_d = ST_STUCK;
      good_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      state_q <= ST_UNLOCK;
      good_q  <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      hv_q    <= 1'b0;
      hp_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      good_q  <= good_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      hv_q    <= hv_d;
      hp_q    <= hp_d;
    end
  end

  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign half_valid  = hv_q;
  assign half_period = hp_q;
  assign locked      = (state_q == ST_LOCKED);
  assign stuck       = (state_q == ST_STUCK);

endmodule
